// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU-source control FSM: state codes,
// ALUSrcB / ALUOp codes, instruction field constants and the per-state
// control word decode.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_IF_DONE  = 4'd1,
        S_DECODE   = 4'd2,
        S_EX_R     = 4'd3,
        S_EX_I     = 4'd4,
        S_EX_LUI   = 4'd5,
        S_BEQ      = 4'd6,
        S_ADDM_RD  = 4'd7,
        S_ADDM_MEM = 4'd8,
        S_ADDM_EX  = 4'd9,
        S_WB_RD    = 4'd10,
        S_WB_RT    = 4'd11,
        S_EXCP     = 4'd12
    } state_t;

    // ALUSrcB mux selects (110/111 are never produced)
    localparam logic [2:0] SRCB_REGB  = 3'b000;
    localparam logic [2:0] SRCB_MDR   = 3'b001;
    localparam logic [2:0] SRCB_SEXT  = 3'b010;
    localparam logic [2:0] SRCB_FOUR  = 3'b011;
    localparam logic [2:0] SRCB_LUI16 = 3'b100;
    localparam logic [2:0] SRCB_OFFS2 = 3'b101;

    // ALU operation codes
    localparam logic [2:0] ALUOP_PASSB = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;

    // Opcode (IR[31:26]) and funct (IR[5:0]) values understood by the sequencer
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDM  = 6'h01;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    // One registered control word; beq_en is later qualified by Zero.
    typedef struct packed {
        logic       mem_read;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic       beq_en;
        logic       aluout_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       exception;
    } ctrl_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
    endfunction

    function automatic logic [2:0] r_aluop(input logic [5:0] funct);
        logic [2:0] op;
        case (funct)
            FN_SUB:  op = ALUOP_SUB;
            FN_AND:  op = ALUOP_AND;
            default: op = ALUOP_ADD;
        endcase
        return op;
    endfunction

    // Control word for a state. 'last' marks the final memory-wait cycle,
    // which is when the data word is captured into MDR.
    function automatic ctrl_t decode(input state_t s, input logic last,
                                     input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: c.mem_read = 1'b1;
            S_IF_DONE: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b    = SRCB_OFFS2;
                c.alu_op       = ALUOP_ADD;
                c.aluout_write = 1'b1;
            end
            S_EX_R: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = SRCB_REGB;
                c.alu_op       = r_aluop(funct);
                c.aluout_write = 1'b1;
            end
            S_EX_I, S_ADDM_RD: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = SRCB_SEXT;
                c.alu_op       = ALUOP_ADD;
                c.aluout_write = 1'b1;
            end
            S_EX_LUI: begin
                c.alu_src_b    = SRCB_LUI16;
                c.alu_op       = ALUOP_PASSB;
                c.aluout_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_SUB;
                c.beq_en    = 1'b1;
            end
            S_ADDM_MEM: begin
                c.mem_read  = 1'b1;
                c.iord      = 1'b1;
                c.mdr_write = last;
            end
            S_ADDM_EX: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = SRCB_MDR;
                c.alu_op       = ALUOP_ADD;
                c.aluout_write = 1'b1;
            end
            S_WB_RD: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_WB_RT: c.reg_write = 1'b1;
            S_EXCP:  c.exception = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_src_sequencer.sv
// Multicycle control FSM for the ALU operand muxes, PC, IR/MDR and register
// file enables. Control outputs are registered alongside the state, so each
// output reflects the state it is shown with; only PCWriteCond is gated by
// the live Zero flag.
//
// After reset is released the FSM spends one idle cycle in S_FETCH with all
// outputs low (the control register is loaded with the S_FETCH word at the
// first edge) before the first memory-wait cycle is counted. This keeps
// every enable quiet through the cycle following release.
module alu_src_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       MemRead,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       ALUOutWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       Exception,
    output logic [3:0] State
);

    localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

    state_t     state;
    state_t     nxt;
    logic [3:0] cnt;
    logic [3:0] nxt_cnt;
    logic       armed;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;

    // Next state and latency counter; the counter is zero on every state exit.
    always_comb begin
        nxt     = state;
        nxt_cnt = 4'd0;
        case (state)
            S_FETCH: begin
                if (cnt == LAST) nxt = S_IF_DONE;
                else             nxt_cnt = cnt + 4'd1;
            end
            S_IF_DONE: nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE: nxt = funct_supported(Funct) ? S_EX_R : S_EXCP;
                    OP_ADDI:  nxt = S_EX_I;
                    OP_LUI:   nxt = S_EX_LUI;
                    OP_BEQ:   nxt = S_BEQ;
                    OP_ADDM:  nxt = S_ADDM_RD;
                    default:  nxt = S_EXCP;
                endcase
            end
            S_EX_R:    nxt = S_WB_RD;
            S_EX_I:    nxt = S_WB_RT;
            S_EX_LUI:  nxt = S_WB_RT;
            S_BEQ:     nxt = S_FETCH;
            S_ADDM_RD: nxt = S_ADDM_MEM;
            S_ADDM_MEM: begin
                if (cnt == LAST) nxt = S_ADDM_EX;
                else             nxt_cnt = cnt + 4'd1;
            end
            S_ADDM_EX: nxt = S_WB_RT;
            S_WB_RD:   nxt = S_FETCH;
            S_WB_RT:   nxt = S_FETCH;
            S_EXCP:    nxt = S_FETCH;
            default:   nxt = S_FETCH;
        endcase
    end

    // Control word for the state being entered; the idle cycle after reset
    // preloads the S_FETCH word without advancing.
    always_comb begin
        ctrl_d = decode(S_FETCH, 1'b0, Funct);
        if (armed) ctrl_d = decode(nxt, (nxt_cnt == LAST), Funct);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            cnt    <= 4'd0;
            armed  <= 1'b0;
            ctrl_q <= '0;
        end else if (!armed) begin
            armed  <= 1'b1;
            ctrl_q <= ctrl_d;
        end else begin
            state  <= nxt;
            cnt    <= nxt_cnt;
            ctrl_q <= ctrl_d;
        end
    end

    assign MemRead     = ctrl_q.mem_read;
    assign IorD        = ctrl_q.iord;
    assign IRWrite     = ctrl_q.ir_write;
    assign MDRWrite    = ctrl_q.mdr_write;
    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.beq_en & Zero;
    assign ALUOutWrite = ctrl_q.aluout_write;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign Exception   = ctrl_q.exception;
    assign State       = state;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Bench for alu_src_sequencer: three instances at MEM_WAIT = 1, 2, 3, each
// with a driver that issues instructions, a reference model that expands an
// instruction into its per-cycle control outputs, and a monitor that pops
// and compares one expected word per clock.
module tb_alu_src_sequencer;
    import alu_ctrl_pkg::*;

    typedef logic [20:0] vq_t[$];

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // clock / reset block (resets are per lane)
    always #5 clk = ~clk;

    // Output word: {MemRead,IorD,IRWrite,MDRWrite,PCWrite,PCWriteCond,
    //  ALUOutWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,Exception,State}
    function automatic logic [20:0] vec(input state_t st,
        input logic mr, input logic iord, input logic irw, input logic mdrw,
        input logic pcw, input logic pcwc, input logic aow, input logic rw,
        input logic rd, input logic sa, input logic [2:0] sb,
        input logic [2:0] op, input logic exc);
        return {mr, iord, irw, mdrw, pcw, pcwc, aow, rw, rd, sa, sb, op, exc, 4'(st)};
    endfunction

    function automatic logic [20:0] idle_word();
        return vec(S_FETCH, 0,0,0,0,0,0,0,0,0,0, 3'b000, 3'b000, 0);
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference model: the cycle-by-cycle control outputs of one instruction.
    task automatic model(input int mw, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, output vq_t seq);
        seq = {};
        for (int i = 0; i < mw; i++)
            seq.push_back(vec(S_FETCH, 1,0,0,0,0,0,0,0,0,0, 3'b000, 3'b000, 0));
        seq.push_back(vec(S_IF_DONE, 0,0,1,0,1,0,0,0,0,0, 3'b011, 3'b001, 0));
        seq.push_back(vec(S_DECODE,  0,0,0,0,0,0,1,0,0,0, 3'b101, 3'b001, 0));
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            logic [2:0] aop;
            aop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            seq.push_back(vec(S_EX_R,  0,0,0,0,0,0,1,0,0,1, 3'b000, aop, 0));
            seq.push_back(vec(S_WB_RD, 0,0,0,0,0,0,0,1,1,0, 3'b000, 3'b000, 0));
        end else if (op == 6'h08) begin
            seq.push_back(vec(S_EX_I,  0,0,0,0,0,0,1,0,0,1, 3'b010, 3'b001, 0));
            seq.push_back(vec(S_WB_RT, 0,0,0,0,0,0,0,1,0,0, 3'b000, 3'b000, 0));
        end else if (op == 6'h0F) begin
            seq.push_back(vec(S_EX_LUI, 0,0,0,0,0,0,1,0,0,0, 3'b100, 3'b000, 0));
            seq.push_back(vec(S_WB_RT,  0,0,0,0,0,0,0,1,0,0, 3'b000, 3'b000, 0));
        end else if (op == 6'h04) begin
            seq.push_back(vec(S_BEQ, 0,0,0,0,0,z,0,0,0,1, 3'b000, 3'b010, 0));
        end else if (op == 6'h01) begin
            seq.push_back(vec(S_ADDM_RD, 0,0,0,0,0,0,1,0,0,1, 3'b010, 3'b001, 0));
            for (int i = 0; i < mw; i++)
                seq.push_back(vec(S_ADDM_MEM, 1,1,0,(i == mw - 1),0,0,0,0,0,0, 3'b000, 3'b000, 0));
            seq.push_back(vec(S_ADDM_EX, 0,0,0,0,0,0,1,0,0,1, 3'b001, 3'b001, 0));
            seq.push_back(vec(S_WB_RT,   0,0,0,0,0,0,0,1,0,0, 3'b000, 3'b000, 0));
        end else begin
            seq.push_back(vec(S_EXCP, 0,0,0,0,0,0,0,0,0,0, 3'b000, 3'b000, 1));
        end
    endtask

    // Directed instructions first, then random ones. Entry RST_IDX (an add)
    // is cut short by a reset while it sits in S_EX_R.
    localparam int ND      = 11;
    localparam int NI      = ND + 30;
    localparam int RST_IDX = 10;
    logic [5:0] dir_op [ND] = '{6'h00, 6'h04, 6'h04, 6'h01, 6'h0F, 6'h08,
                                6'h00, 6'h00, 6'h3F, 6'h00, 6'h00};
    logic [5:0] dir_fn [ND] = '{6'h20, 6'h00, 6'h00, 6'h11, 6'h2A, 6'h05,
                                6'h22, 6'h24, 6'h20, 6'h27, 6'h20};
    logic       dir_z  [ND] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int MW = g + 1;

        logic        reset;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic        zero;
        logic        mem_read, iord, ir_write, mdr_write, pc_write, pc_write_cond;
        logic        aluout_write, reg_write, reg_dst, alu_src_a, exception;
        logic [2:0]  alu_src_b, alu_op;
        logic [3:0]  state;
        logic [20:0] act;
        logic [20:0] exp_q[$];
        logic [20:0] e_mon;
        bit          mon_en = 1'b0;
        bit          done   = 1'b0;
        int          cyc    = 0;

        alu_src_sequencer #(.MEM_WAIT(MW)) dut (
            .clk        (clk),
            .reset      (reset),
            .Opcode     (opcode),
            .Funct      (funct),
            .Zero       (zero),
            .MemRead    (mem_read),
            .IorD       (iord),
            .IRWrite    (ir_write),
            .MDRWrite   (mdr_write),
            .PCWrite    (pc_write),
            .PCWriteCond(pc_write_cond),
            .ALUOutWrite(aluout_write),
            .RegWrite   (reg_write),
            .RegDst     (reg_dst),
            .ALUSrcA    (alu_src_a),
            .ALUSrcB    (alu_src_b),
            .ALUOp      (alu_op),
            .Exception  (exception),
            .State      (state)
        );

        assign act = {mem_read, iord, ir_write, mdr_write, pc_write, pc_write_cond,
                      aluout_write, reg_write, reg_dst, alu_src_a, alu_src_b,
                      alu_op, exception, state};

        // monitor: one expected word per clock, sampled mid-cycle
        always @(negedge clk) begin
            if (mon_en) begin
                cyc++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lane%0d underflow cyc%0d act=%h exp=none", g, cyc, act);
                end else begin
                    e_mon = exp_q.pop_front();
                    check($sformatf("lane%0d cyc%0d", g, cyc), act, e_mon);
                end
            end
        end

        // driver
        initial begin
            vq_t        seq;
            logic [5:0] op;
            logic [5:0] fn;
            logic       z;
            int         r;
            reset  = 1'b0;
            opcode = 6'h00;
            funct  = 6'h00;
            zero   = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("lane%0d power-on reset", g), act, idle_word());
            reset  = 1'b1;
            exp_q.push_back(idle_word());
            mon_en = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (i < ND) begin
                    op = dir_op[i];
                    fn = dir_fn[i];
                    z  = dir_z[i];
                end else begin
                    r = $urandom_range(0, 7);
                    case (r)
                        0, 5:    op = 6'h00;
                        1:       op = 6'h08;
                        2:       op = 6'h0F;
                        3:       op = 6'h04;
                        4:       op = 6'h01;
                        default: op = 6'($urandom_range(0, 63));
                    endcase
                    r = $urandom_range(0, 3);
                    fn = (r == 0) ? 6'h20 : (r == 1) ? 6'h22 : (r == 2) ? 6'h24
                                                            : 6'($urandom_range(0, 63));
                    z  = 1'($urandom_range(0, 1));
                end
                model(MW, op, fn, z, seq);
                opcode = op;
                funct  = fn;
                zero   = z;
                if (i == RST_IDX) begin
                    // keep fetch, if_done, decode and ex_r, then reset in ex_r
                    while (seq.size() > MW + 3) void'(seq.pop_back());
                    foreach (seq[k]) exp_q.push_back(seq[k]);
                    repeat (MW + 2) @(posedge clk);
                    @(negedge clk);
                    #1;
                    mon_en = 1'b0;
                    reset  = 1'b0;
                    #1;
                    check($sformatf("lane%0d async reset", g), act, idle_word());
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check($sformatf("lane%0d reset hold%0d", g, k), act, idle_word());
                    end
                    @(posedge clk);
                    #1;
                    reset  = 1'b1;
                    exp_q.push_back(idle_word());
                    mon_en = 1'b1;
                    @(posedge clk);
                    #1;
                end else begin
                    foreach (seq[k]) exp_q.push_back(seq[k]);
                    repeat (seq.size()) @(posedge clk);
                    #1;
                end
            end
            mon_en = 1'b0;
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL lane%0d drain left=%0d exp=0", g, exp_q.size());
            end
            done = 1'b1;
        end
    end

    // final report
    initial begin
        int t;
        t = 0;
        while (!(lane[0].done && lane[1].done && lane[2].done) && t < 60000) begin
            #10;
            t++;
        end
        if (!(lane[0].done && lane[1].done && lane[2].done)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout act=not_done exp=done");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
